// File: rtl/fetch_ctrl_if.sv
// Bus between fetch_ctrl and the datapath / instruction memory.
// master: fetch_ctrl side (drives imem_addr, instr, cntrl, store_flags).
interface fetch_ctrl_if #(
    parameter int WIDTH = 64
);
    logic [31:0]      imem_data;
    logic [3:0]       flags;
    logic [1:0]       Reg_B_Tests;
    logic [WIDTH-1:0] imem_addr;
    logic [31:0]      instr;
    logic [19:0]      cntrl;
    logic [3:0]       store_flags;

    modport master (
        input  imem_data, flags, Reg_B_Tests,
        output imem_addr, instr, cntrl, store_flags
    );

    modport slave (
        output imem_data, flags, Reg_B_Tests,
        input  imem_addr, instr, cntrl, store_flags
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch/ID control: PC, IF/ID register, decode, ID-stage branches
// with one delay slot, flag register and load-use bubbles.
// Ports: clk, reset (sync, active-high), bus (fetch_ctrl_if.master).
module fetch_ctrl #(
    parameter int          WIDTH     = 64,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    localparam int RD_EN   = 7;
    localparam int MEM_WR  = 10;
    localparam int REG_WR  = 11;
    localparam int MEM2REG = 12;
    localparam int ALU_SRC = 13;
    localparam int R2LOC   = 14;
    localparam int SET_FL  = 15;
    localparam int D9_SEL  = 16;
    localparam int LDB_EXT = 17;
    localparam int MOVZK   = 18;
    localparam int MOV_SEL = 19;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] id_pc;
    logic [31:0]      id_instr;
    logic             ex_rd_en;
    logic             ex_set_fl;
    logic [4:0]       ex_rd;
    logic [3:0]       flag_reg;

    logic [10:0] op11;
    logic is_addi, is_adds, is_subs, is_ldur, is_ldurb;
    logic is_stur, is_sturb, is_movz, is_movk;
    logic is_b, is_cbz, is_blt;

    assign op11     = id_instr[31:21];
    assign is_addi  = id_instr[31:22] == 10'b1001000100;
    assign is_adds  = op11 == 11'b10101011000;
    assign is_subs  = op11 == 11'b11101011000;
    assign is_ldur  = op11 == 11'b11111000010;
    assign is_ldurb = op11 == 11'b00111000010;
    assign is_stur  = op11 == 11'b11111000000;
    assign is_sturb = op11 == 11'b00111000000;
    assign is_movz  = id_instr[31:23] == 9'b110100101;
    assign is_movk  = id_instr[31:23] == 9'b111100101;
    assign is_b     = id_instr[31:26] == 6'b000101;
    assign is_cbz   = id_instr[31:24] == 8'b10110100;
    assign is_blt   = (id_instr[31:24] == 8'b01010100) &&
                      (id_instr[4:0] == 5'b01011);

    logic [19:0] dec;

    always_comb begin
        dec = '0;
        unique case (1'b1)
            is_addi: begin
                dec[6:4]     = 3'b010;
                dec[ALU_SRC] = 1'b1;
                dec[REG_WR]  = 1'b1;
                dec[MOV_SEL] = 1'b1;
            end
            is_adds, is_subs: begin
                dec[6:4]     = is_subs ? 3'b011 : 3'b010;
                dec[R2LOC]   = 1'b1;
                dec[REG_WR]  = 1'b1;
                dec[SET_FL]  = 1'b1;
                dec[MOV_SEL] = 1'b1;
            end
            is_ldur, is_ldurb: begin
                dec[3:0]     = is_ldur ? 4'd8 : 4'd1;
                dec[6:4]     = 3'b010;
                dec[RD_EN]   = 1'b1;
                dec[REG_WR]  = 1'b1;
                dec[MEM2REG] = 1'b1;
                dec[ALU_SRC] = 1'b1;
                dec[D9_SEL]  = 1'b1;
                dec[LDB_EXT] = is_ldurb;
                dec[MOV_SEL] = 1'b1;
            end
            is_stur, is_sturb: begin
                dec[3:0]     = is_stur ? 4'd8 : 4'd1;
                dec[6:4]     = 3'b010;
                dec[MEM_WR]  = 1'b1;
                dec[ALU_SRC] = 1'b1;
                dec[D9_SEL]  = 1'b1;
            end
            is_movz, is_movk: begin
                dec[REG_WR]  = 1'b1;
                dec[MOVZK]   = is_movz;
            end
            default: dec = '0;
        endcase
    end

    // Load-use: the ID instruction reads the register a load in EX writes.
    logic [4:0] rn, r2;
    logic       use_rn, use_r2, stall;

    assign rn     = id_instr[9:5];
    assign r2     = dec[R2LOC] ? id_instr[20:16] : id_instr[4:0];
    assign use_rn = is_addi | is_adds | is_subs | is_ldur | is_ldurb |
                    is_stur | is_sturb;
    assign use_r2 = is_adds | is_subs | is_stur | is_sturb | is_movk |
                    is_cbz;
    assign stall  = ex_rd_en && (ex_rd != 5'd31) &&
                    ((use_rn && rn == ex_rd) || (use_r2 && r2 == ex_rd));

    logic [WIDTH-1:0] br_off;
    logic             taken;

    assign br_off = is_b
        ? {{(WIDTH-28){id_instr[25]}}, id_instr[25:0], 2'b00}
        : {{(WIDTH-21){id_instr[23]}}, id_instr[23:5], 2'b00};
    assign taken  = !stall && (is_b || (is_cbz && bus.Reg_B_Tests[1]) ||
                               (is_blt && bus.Reg_B_Tests[0]));

    logic [31:0] issue_instr;
    logic [19:0] issue_cntrl;

    assign issue_instr     = stall ? NOP_INSTR : id_instr;
    assign issue_cntrl     = stall ? 20'd0 : dec;
    assign bus.imem_addr   = pc;
    assign bus.instr       = issue_instr;
    assign bus.cntrl       = issue_cntrl;
    assign bus.store_flags = flag_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            id_pc     <= '0;
            id_instr  <= NOP_INSTR;
            ex_rd_en  <= 1'b0;
            ex_set_fl <= 1'b0;
            ex_rd     <= 5'd31;
            flag_reg  <= 4'd0;
        end else begin
            if (ex_set_fl)
                flag_reg <= bus.flags;
            // A bubble carries NOP (Rd=31) and zero control into EX.
            ex_rd_en  <= issue_cntrl[RD_EN];
            ex_set_fl <= issue_cntrl[SET_FL];
            ex_rd     <= issue_instr[4:0];
            if (!stall) begin
                id_instr <= bus.imem_data;
                id_pc    <= pc;
                pc       <= taken ? id_pc + br_off : pc + WIDTH'(4);
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random
// programs compared against an instruction-level reference model.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP = 32'hD503201F;

    typedef enum int {
        K_OTHER, K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_LDURB,
        K_STUR, K_STURB, K_MOVZ, K_MOVK, K_B, K_CBZ, K_BLT
    } kind_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:63];

    fetch_ctrl_if #(.WIDTH(64)) bus ();

    fetch_ctrl #(.WIDTH(64), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = (bus.imem_addr[63:8] == 56'd0)
                         ? mem[bus.imem_addr[7:2]] : NOP;

    // ---------------- reference model ----------------
    logic [63:0] m_pc, m_id_pc;
    logic [31:0] m_id;
    logic        m_ex_ld, m_ex_sf;
    logic [4:0]  m_ex_rd;
    logic [3:0]  m_flags;
    logic [63:0] e_addr;
    logic [31:0] e_instr;
    logic [19:0] e_cntrl;
    logic [3:0]  e_sf;

    function automatic logic [31:0] fetch_word(logic [63:0] a);
        return (a[63:8] == 56'd0) ? mem[a[7:2]] : NOP;
    endfunction

    function automatic kind_t kind_of(logic [31:0] i);
        if (i[31:22] == 10'b1001000100) return K_ADDI;
        case (i[31:21])
            11'b10101011000: return K_ADDS;
            11'b11101011000: return K_SUBS;
            11'b11111000010: return K_LDUR;
            11'b00111000010: return K_LDURB;
            11'b11111000000: return K_STUR;
            11'b00111000000: return K_STURB;
            default: ;
        endcase
        if (i[31:23] == 9'b110100101) return K_MOVZ;
        if (i[31:23] == 9'b111100101) return K_MOVK;
        if (i[31:26] == 6'b000101) return K_B;
        if (i[31:24] == 8'b10110100) return K_CBZ;
        if (i[31:24] == 8'b01010100 && i[4:0] == 5'd11) return K_BLT;
        return K_OTHER;
    endfunction

    function automatic logic [19:0] ref_ctrl(logic [31:0] i);
        logic [19:0] c;
        kind_t k;
        c = '0;
        k = kind_of(i);
        case (k)
            K_ADDI: begin
                c[6:4] = 3'd2; c[13] = 1; c[11] = 1; c[19] = 1;
            end
            K_ADDS, K_SUBS: begin
                c[6:4] = (k == K_ADDS) ? 3'd2 : 3'd3;
                c[14] = 1; c[11] = 1; c[15] = 1; c[19] = 1;
            end
            K_LDUR, K_LDURB: begin
                c[3:0] = (k == K_LDUR) ? 4'd8 : 4'd1;
                c[6:4] = 3'd2; c[7] = 1; c[11] = 1; c[12] = 1;
                c[13] = 1; c[16] = 1; c[17] = (k == K_LDURB); c[19] = 1;
            end
            K_STUR, K_STURB: begin
                c[3:0] = (k == K_STUR) ? 4'd8 : 4'd1;
                c[6:4] = 3'd2; c[10] = 1; c[13] = 1; c[16] = 1;
            end
            K_MOVZ: begin c[11] = 1; c[18] = 1; end
            K_MOVK: c[11] = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit reads(logic [31:0] i, logic [4:0] r);
        case (kind_of(i))
            K_ADDI, K_LDUR, K_LDURB: return i[9:5] == r;
            K_ADDS, K_SUBS: return i[9:5] == r || i[20:16] == r;
            K_STUR, K_STURB: return i[9:5] == r || i[4:0] == r;
            K_MOVK, K_CBZ: return i[4:0] == r;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_stalled();
        return m_ex_ld && m_ex_rd != 5'd31 && reads(m_id, m_ex_rd);
    endfunction

    function automatic void model_eval();
        bit st;
        st      = m_stalled();
        e_addr  = m_pc;
        e_instr = st ? NOP : m_id;
        e_cntrl = st ? 20'd0 : ref_ctrl(m_id);
        e_sf    = m_flags;
    endfunction

    function automatic void model_step();
        kind_t       k;
        longint      off;
        logic [63:0] tgt;
        bit          tk;
        if (reset) begin
            m_pc = 0; m_id_pc = 0; m_id = NOP;
            m_ex_ld = 0; m_ex_sf = 0; m_ex_rd = 31; m_flags = 0;
            return;
        end
        if (m_ex_sf) m_flags = bus.flags;
        if (m_stalled()) begin
            m_ex_ld = 0; m_ex_sf = 0; m_ex_rd = 31;
            return;
        end
        k = kind_of(m_id);
        if (k == K_B) off = longint'($signed(m_id[25:0]));
        else off = longint'($signed(m_id[23:5]));
        tgt = m_id_pc + 64'(off * 4);
        tk = (k == K_B) || (k == K_CBZ && bus.Reg_B_Tests[1]) ||
             (k == K_BLT && bus.Reg_B_Tests[0]);
        m_ex_ld = (k == K_LDUR || k == K_LDURB);
        m_ex_sf = (k == K_ADDS || k == K_SUBS);
        m_ex_rd = m_id[4:0];
        m_id_pc = m_pc;
        m_id    = fetch_word(m_pc);
        m_pc    = tk ? tgt : m_pc + 64'd4;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = NOP;
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- encodings ----------------
    localparam logic [31:0] I_ADDI  = {10'b1001000100, 12'd5, 5'd0, 5'd1};
    localparam logic [31:0] I_SUBS  = {11'b11101011000, 5'd1, 6'd0, 5'd1, 5'd2};
    localparam logic [31:0] I_B3    = {6'b000101, 26'd3};
    localparam logic [31:0] I_BM4   = {6'b000101, 26'h3FFFFFC};
    localparam logic [31:0] I_LD3   = {11'b11111000010, 9'd0, 2'b00, 5'd4, 5'd3};
    localparam logic [31:0] I_LD31  = {11'b11111000010, 9'd0, 2'b00, 5'd4, 5'd31};
    localparam logic [31:0] I_ADDS  = {11'b10101011000, 5'd6, 6'd0, 5'd3, 5'd5};

    function automatic logic [4:0] rreg();
        int u;
        u = $urandom_range(0, 5);
        return (u == 5) ? 5'd31 : 5'(u);
    endfunction

    function automatic logic [31:0] rand_instr();
        int s;
        s = $urandom_range(0, 9) - 3;
        case ($urandom_range(0, 12))
            0: return {10'b1001000100, 12'($urandom), rreg(), rreg()};
            1: return {11'b10101011000, rreg(), 6'd0, rreg(), rreg()};
            2: return {11'b11101011000, rreg(), 6'd0, rreg(), rreg()};
            3: return {11'b11111000010, 9'($urandom), 2'b00, rreg(), rreg()};
            4: return {11'b00111000010, 9'($urandom), 2'b00, rreg(), rreg()};
            5: return {11'b11111000000, 9'($urandom), 2'b00, rreg(), rreg()};
            6: return {11'b00111000000, 9'($urandom), 2'b00, rreg(), rreg()};
            7: return {9'b110100101, 2'b00, 16'($urandom), rreg()};
            8: return {9'b111100101, 2'b00, 16'($urandom), rreg()};
            9: return {6'b000101, 26'(s)};
            10: return {8'b10110100, 19'(s), rreg()};
            11: return {8'b01010100, 19'(s), 5'd11};
            default: return NOP;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_mem();
        reset = 1'b1;
        bus.flags = 4'hF;
        bus.Reg_B_Tests = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.imem_addr !== 64'd0 || bus.instr !== NOP ||
                bus.cntrl !== 20'd0 || bus.store_flags !== 4'd0) begin
                errors++;
                $display("FAIL reset_state: got addr=%h instr=%h cntrl=%h sf=%h",
                         bus.imem_addr, bus.instr, bus.cntrl, bus.store_flags);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.imem_addr !== 64'(i * 4)) begin
                errors++;
                $display("FAIL reset_release: got addr=%h expected %h",
                         bus.imem_addr, 64'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_decode_flags();
        clear_mem();
        mem[0] = I_ADDI;
        mem[1] = I_SUBS;
        restart();
        for (int c = 0; c < 6; c++) begin
            bus.flags = (c == 3) ? 4'b1000 : 4'($urandom);
            bus.Reg_B_Tests = 2'($urandom);
            #1;
            model_eval();
            checks++;
            if ({bus.imem_addr, bus.instr, bus.cntrl, bus.store_flags} !==
                {e_addr, e_instr, e_cntrl, e_sf}) begin
                errors++;
                $display("FAIL decode_model c%0d: got %h %h %h %h expected %h %h %h %h",
                         c, bus.imem_addr, bus.instr, bus.cntrl, bus.store_flags,
                         e_addr, e_instr, e_cntrl, e_sf);
            end
            if (c == 1) begin
                checks++;
                if (bus.cntrl !== 20'h82820) begin
                    errors++;
                    $display("FAIL addi_cntrl: got %h expected 82820", bus.cntrl);
                end
            end
            if (c == 2) begin
                checks++;
                if (bus.cntrl[15] !== 1'b1) begin
                    errors++;
                    $display("FAIL subs_setflags: got %b expected 1", bus.cntrl[15]);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.store_flags !== 4'b1000) begin
                    errors++;
                    $display("FAIL store_flags: got %b expected 1000",
                             bus.store_flags);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        clear_mem();
        mem[4] = I_B3;
        mem[5] = I_ADDI;
        bus.Reg_B_Tests = 2'b00;
        restart();
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c == 6) begin
                checks++;
                if (bus.imem_addr !== 64'h1C || bus.instr !== I_ADDI) begin
                    errors++;
                    $display("FAIL b_fwd: got addr=%h instr=%h expected 1c %h",
                             bus.imem_addr, bus.instr, I_ADDI);
                end
            end
            tick();
        end
        clear_mem();
        mem[0] = I_BM4;
        restart();
        for (int c = 0; c < 4; c++) begin
            #1;
            if (c == 2) begin
                checks++;
                if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFF0) begin
                    errors++;
                    $display("FAIL b_wrap: got %h expected fffffffffffffff0",
                             bus.imem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_cbz();
        logic [63:0] exp_a;
        for (int v = 0; v < 4; v++) begin
            clear_mem();
            mem[8] = {8'b10110100, 19'((v < 2) ? 2 : 4), 5'd2};
            bus.Reg_B_Tests = v[0] ? 2'b10 : 2'b00;
            restart();
            exp_a = (v == 3) ? 64'h30 : 64'h28;
            for (int c = 0; c < 12; c++) begin
                #1;
                if (c == 10) begin
                    checks++;
                    if (bus.imem_addr !== exp_a) begin
                        errors++;
                        $display("FAIL cbz_v%0d: got %h expected %h",
                                 v, bus.imem_addr, exp_a);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_load_use();
        for (int v = 0; v < 2; v++) begin
            clear_mem();
            mem[0] = (v == 0) ? I_LD3 : I_LD31;
            mem[1] = I_ADDS;
            restart();
            for (int c = 0; c < 5; c++) begin
                #1;
                if (v == 0 && c == 2) begin
                    checks++;
                    if (bus.instr !== NOP || bus.cntrl !== 20'd0 ||
                        bus.imem_addr !== 64'h8) begin
                        errors++;
                        $display("FAIL bubble: got instr=%h cntrl=%h addr=%h",
                                 bus.instr, bus.cntrl, bus.imem_addr);
                    end
                end
                if (c == 3) begin
                    checks++;
                    if (bus.instr !== ((v == 0) ? I_ADDS : NOP) ||
                        bus.imem_addr !== ((v == 0) ? 64'h8 : 64'hC)) begin
                        errors++;
                        $display("FAIL after_load_v%0d: got instr=%h addr=%h",
                                 v, bus.instr, bus.imem_addr);
                    end
                end
                if (v == 1 && c == 2) begin
                    checks++;
                    if (bus.instr !== I_ADDS || bus.cntrl[11] !== 1'b1) begin
                        errors++;
                        $display("FAIL no_bubble_x31: got instr=%h cntrl=%h",
                                 bus.instr, bus.cntrl);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_in_stall();
        clear_mem();
        mem[0] = I_LD3;
        mem[1] = I_ADDS;
        restart();
        for (int c = 0; c < 6; c++) begin
            reset = (c == 2);
            #1;
            if (c == 3) begin
                checks++;
                if (bus.imem_addr !== 64'd0 || bus.instr !== NOP ||
                    bus.cntrl !== 20'd0) begin
                    errors++;
                    $display("FAIL stall_reset: got addr=%h instr=%h cntrl=%h",
                             bus.imem_addr, bus.instr, bus.cntrl);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.imem_addr !== 64'd4 || bus.instr !== I_LD3) begin
                    errors++;
                    $display("FAIL stall_restart: got addr=%h instr=%h",
                             bus.imem_addr, bus.instr);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = rand_instr();
            restart();
            for (int c = 0; c < 200; c++) begin
                reset = ($urandom_range(0, 59) == 0);
                bus.flags = 4'($urandom);
                bus.Reg_B_Tests = 2'($urandom);
                #1;
                model_eval();
                checks++;
                if ({bus.imem_addr, bus.instr, bus.cntrl, bus.store_flags} !==
                    {e_addr, e_instr, e_cntrl, e_sf}) begin
                    errors++;
                    $display("FAIL random r%0d c%0d: got %h %h %h %h expected %h %h %h %h",
                             r, c, bus.imem_addr, bus.instr, bus.cntrl,
                             bus.store_flags, e_addr, e_instr, e_cntrl, e_sf);
                end
                tick();
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.flags = 4'd0;
        bus.Reg_B_Tests = 2'd0;
        test_reset();
        test_decode_flags();
        test_branch();
        test_cbz();
        test_load_use();
        test_reset_in_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
